play_time_bcd: RTL and testbench

- Converts the player's RAM read address into an elapsed or remaining play time, shown as BCD minutes:seconds for the seven-segment display driver.
- Generalised successor of the single-format start-time counter: configurable address width, address-to-second shift and minute digit count, plus a count-down mode, overflow handling and a status handshake.
- Sits between the RAM address generator and the display scan module.

---
 rtl/play_time_bcd.sv | 120 ++++++++++++
 tb/tb_play_time_bcd.sv | 133 +++++++++++++
 2 files changed

// File: rtl/play_time_bcd.sv
// play_time_bcd: turns the RAM playback address into elapsed or remaining time as BCD MM..M:SS.
module play_time_bcd #(
    parameter int unsigned ADDR_W     = 12,
    parameter int unsigned ADDR_SHIFT = 2,
    parameter int unsigned MIN_DIGITS = 2,
    parameter bit          SAT_EN     = 1'b1,
    localparam int unsigned TW = ADDR_W - ADDR_SHIFT,
    localparam int unsigned OW = 4 * (MIN_DIGITS + 2)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [ADDR_W-1:0] ram_addr_out,
    input  logic [ADDR_W-1:0] total_addr,
    input  logic              mode,
    output logic [OW-1:0]     time_bcd,
    output logic              time_valid,
    output logic              busy,
    output logic              overflow
);
    typedef enum logic [1:0] {INIT, IDLE, COUNT} state_t;

    localparam logic [OW-1:0] MAX = {{MIN_DIGITS{4'h9}}, 8'h59};

    state_t          state_q, state_d;
    logic [TW-1:0]   tgt_q, tgt_d, cnt_q, cnt_d, cur_s, tot_s, t_sec;
    logic [OW-1:0]   work_q, work_d, bcd_q, bcd_d, inc_v;
    logic            ovf_q, ovf_d, mode_q, mode_d, inc_c, restart;
    logic            valid_q, valid_d, busy_q, busy_d, oflow_q, oflow_d;

    // Seconds digit tens wraps at 5, every other digit at 9; returns {carry_out, value}.
    function automatic logic [OW:0] bcd_inc(input logic [OW-1:0] v);
        logic [OW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < int'(MIN_DIGITS) + 2; i++) begin
            if (c) begin
                if (r[4*i +: 4] == ((i == 1) ? 4'd5 : 4'd9)) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    assign cur_s = ram_addr_out[ADDR_W-1:ADDR_SHIFT];
    assign tot_s = total_addr[ADDR_W-1:ADDR_SHIFT];
    assign t_sec = mode ? ((tot_s > cur_s) ? tot_s - cur_s : '0) : cur_s;
    assign restart = (state_q == INIT) || (t_sec != tgt_q) || (mode != mode_q);

    always_comb begin
        {inc_c, inc_v} = bcd_inc(work_q);
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        ovf_d   = ovf_q;
        mode_d  = mode_q;
        bcd_d   = bcd_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        oflow_d = oflow_q;
        if (restart) begin
            tgt_d   = t_sec;
            mode_d  = mode;
            cnt_d   = '0;
            work_d  = '0;
            ovf_d   = 1'b0;
            busy_d  = 1'b1;
            valid_d = 1'b0;
            state_d = COUNT;
        end else if (state_q == COUNT) begin
            if (cnt_q == tgt_q) begin
                bcd_d   = work_q;
                oflow_d = ovf_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end else begin
                cnt_d  = cnt_q + TW'(1);
                work_d = inc_c ? (SAT_EN ? MAX : '0) : inc_v;
                ovf_d  = ovf_q | inc_c;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= INIT;
            tgt_q   <= '0;
            cnt_q   <= '0;
            work_q  <= '0;
            ovf_q   <= 1'b0;
            mode_q  <= 1'b0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            oflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            ovf_q   <= ovf_d;
            mode_q  <= mode_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            oflow_q <= oflow_d;
        end
    end

    assign time_bcd   = bcd_q;
    assign time_valid = valid_q;
    assign busy       = busy_q;
    assign overflow   = oflow_q;
endmodule

// File: tb/tb_play_time_bcd.sv
// tb_play_time_bcd: directed vectors; expected {overflow, time_bcd} queued per DUT, popped on each time_valid rise.
module tb_play_time_bcd;
    logic        clk = 1'b0, rst = 1'b1;
    logic [11:0] addr_a = '0, tot_a = '0;
    logic [15:0] addr_b = '0, tot_b = '0;
    logic        mode_a = 1'b0, mode_b = 1'b0;
    logic [15:0] bcd_a, bcd_b, bcd_c;
    logic        val_a, val_b, val_c, busy_a, busy_b, busy_c, ovf_a, ovf_b, ovf_c;
    int          checks = 0, errors = 0;
    logic [16:0] q_a[$], q_b[$], q_c[$];

    always #5 clk = ~clk;

    play_time_bcd dut_a (
        .sys_clk(clk), .sys_rst(rst), .ram_addr_out(addr_a), .total_addr(tot_a), .mode(mode_a),
        .time_bcd(bcd_a), .time_valid(val_a), .busy(busy_a), .overflow(ovf_a));
    play_time_bcd #(.ADDR_W(16), .ADDR_SHIFT(0), .MIN_DIGITS(2), .SAT_EN(1'b1)) dut_b (
        .sys_clk(clk), .sys_rst(rst), .ram_addr_out(addr_b), .total_addr(tot_b), .mode(mode_b),
        .time_bcd(bcd_b), .time_valid(val_b), .busy(busy_b), .overflow(ovf_b));
    play_time_bcd #(.ADDR_W(16), .ADDR_SHIFT(0), .MIN_DIGITS(2), .SAT_EN(1'b0)) dut_c (
        .sys_clk(clk), .sys_rst(rst), .ram_addr_out(addr_b), .total_addr(tot_b), .mode(mode_b),
        .time_bcd(bcd_c), .time_valid(val_c), .busy(busy_c), .overflow(ovf_c));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per DUT whenever that DUT's time_valid rises.
    initial begin
        logic pa, pb, pc;
        pa = 1'b0; pb = 1'b0; pc = 1'b0;
        forever begin
            @(negedge clk);
            if (val_a && !pa) begin
                if (q_a.size() == 0) chk("a_unexpected", {15'd0, ovf_a, bcd_a}, 32'hFFFF_FFFF);
                else chk("a_result", {15'd0, ovf_a, bcd_a}, {15'd0, q_a.pop_front()});
            end
            if (val_b && !pb) begin
                if (q_b.size() == 0) chk("b_unexpected", {15'd0, ovf_b, bcd_b}, 32'hFFFF_FFFF);
                else chk("b_result", {15'd0, ovf_b, bcd_b}, {15'd0, q_b.pop_front()});
            end
            if (val_c && !pc) begin
                if (q_c.size() == 0) chk("c_unexpected", {15'd0, ovf_c, bcd_c}, 32'hFFFF_FFFF);
                else chk("c_result", {15'd0, ovf_c, bcd_c}, {15'd0, q_c.pop_front()});
            end
            pa = val_a; pb = val_b; pc = val_c;
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        @(posedge clk); #1;
        while (!(val_a && val_b && val_c) && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, 32'(n < 20000), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_bcd", {16'd0, bcd_a}, 32'h0);
        chk("rst_valid", {31'd0, val_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_ovf", {31'd0, ovf_a}, 32'd0);
        q_a.push_back(17'h0_0000); q_b.push_back(17'h0_0000); q_c.push_back(17'h0_0000);
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("init_valid", {31'd0, val_a}, 32'd1);
        chk("init_busy", {31'd0, busy_a}, 32'd0);
        chk("init_bcd", {16'd0, bcd_a}, 32'h0);

        @(negedge clk); addr_a = 12'h0F0; q_a.push_back(17'h0_0100);
        @(posedge clk); #1;
        n = 0;
        while (busy_a && n < 1000) begin
            n++;
            @(posedge clk); #1;
        end
        chk("busy_cycles_60s", 32'(n), 32'd61);
        @(negedge clk); addr_a = 12'h0EC; q_a.push_back(17'h0_0059);
        wait_idle("idle_59s");

        mode_a = 1'b1; tot_a = 12'h960; addr_a = 12'h0F0; q_a.push_back(17'h0_0900);
        wait_idle("idle_remain540");
        addr_a = 12'hA00; q_a.push_back(17'h0_0000);
        wait_idle("idle_remain_neg");

        addr_b = 16'd6000; q_b.push_back(17'h1_9959); q_c.push_back(17'h1_0000);
        wait_idle("idle_6000");
        addr_b = 16'd5999; q_b.push_back(17'h0_9959); q_c.push_back(17'h0_9959);
        wait_idle("idle_5999");

        mode_a = 1'b0; addr_a = 12'h0F0;
        repeat (30) @(posedge clk);
        #1;
        chk("mid_busy", {31'd0, busy_a}, 32'd1);
        chk("mid_valid", {31'd0, val_a}, 32'd0);
        chk("mid_hold_bcd", {16'd0, bcd_a}, 32'h0);
        @(negedge clk); addr_a = 12'h028; q_a.push_back(17'h0_0010);
        wait_idle("idle_mid_restart");

        addr_a = 12'h0F0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_bcd", {16'd0, bcd_a}, 32'h0);
        chk("async_rst_valid", {31'd0, val_a}, 32'd0);
        chk("async_rst_busy", {31'd0, busy_a}, 32'd0);
        chk("async_rst_b_bcd", {16'd0, bcd_b}, 32'h0);
        addr_a = 12'h008; addr_b = 16'd0;
        q_a.push_back(17'h0_0002); q_b.push_back(17'h0_0000); q_c.push_back(17'h0_0000);
        @(negedge clk); rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_valid", {31'd0, val_a}, 32'd1);
        wait_idle("idle_post_rst");
        repeat (3) @(negedge clk);
        chk("q_a_empty", 32'(q_a.size()), 32'd0);
        chk("q_b_empty", 32'(q_b.size()), 32'd0);
        chk("q_c_empty", 32'(q_c.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
